de1_key_conditioner: RTL
========================

# de1_key_conditioner

Conditions the four raw active-low DE1-SoC pushbuttons before they reach the HPS system's `keys_export` PIO input. Each key gets a 2-flop synchronizer, a per-key debounce state machine, and single-cycle press/release strobes. `keys_level` drives `keys_export` directly. The strobes feed fabric-side logic such as the annealer start/step controls.

## Interface

Parameters:
- `N_KEYS`, default 4: number of keys.
- `DEBOUNCE_CYCLES`, default 1000000: stable cycles required to accept a change (20 ms at 50 MHz). Must be ≥ 2.
- `REPEAT_DELAY`, default 25000000: cycles from accepted press to the first repeat strobe. Used only with the auto-repeat macro.
- `REPEAT_PERIOD`, default 5000000: cycles between subsequent repeat strobes. Used only with the auto-repeat macro.
- `CNT_W`, default 32: width of the debounce and repeat counters. Must hold the largest of the three count parameters.

Ports:
- `clk_clk` in 1: system clock.
- `reset_reset_n` in 1: synchronous, active-low reset.
- `key_n` in `N_KEYS`: raw pushbuttons, active-low, asynchronous to `clk_clk`.
- `keys_level` out `N_KEYS`: debounced level, 1 = held. Drives `keys_export`.
- `press_pulse` out `N_KEYS`: 1-cycle strobe on accepted press (and on repeats, if enabled).
- `release_pulse` out `N_KEYS`: 1-cycle strobe on accepted release.
- `any_press` out 1: OR of `press_pulse`, registered with it (same cycle).

## Operation

- Synchronizer: `key_n` passes through two flops. Both reset to 1 (released). `pressed_s = ~sync2`.
- Keys are fully independent. Each key has its own FSM, counter and outputs. Simultaneous activity on any subset of keys is legal and must not interact.
- Per-key FSM states are UP, UP_CHK, DOWN and DN_CHK. Reset state is UP with counter 0.
- In UP:
  - `pressed_s` = 1: go to UP_CHK, counter ← 1.
  - Otherwise stay in UP, counter ← 0.
- In UP_CHK:
  - `pressed_s` = 0: go to UP, counter ← 0. This is a glitch; no strobe.
  - Else if counter == `DEBOUNCE_CYCLES`−1: go to DOWN, `keys_level` ← 1, `press_pulse` ← 1, counter ← 0.
  - Else counter ← counter+1.
- In DOWN:
  - `pressed_s` = 0: go to DN_CHK, counter ← 1.
- In DN_CHK:
  - `pressed_s` = 1: go to DOWN. The repeat timer is not reset.
  - Else if counter == `DEBOUNCE_CYCLES`−1: go to UP, `keys_level` ← 0, `release_pulse` ← 1.
  - Else counter ← counter+1.
- `press_pulse` and `release_pulse` default to 0 every cycle. They are never asserted together for the same key.
- Counters never wrap; they stop at the terminal compare.
- Reset mid-operation: everything returns to the reset state and no strobes are emitted.
  - A key still held through reset is re-debounced from UP.
  - Its `press_pulse` fires `DEBOUNCE_CYCLES`+1 cycles after the synchronizer sees the press.

## Timing

- Reset values: `keys_level` = 0, `press_pulse` = 0, `release_pulse` = 0, `any_press` = 0, sync flops = 1, FSM = UP, all counters = 0.
- Press latency, with raw low first sampled at edge 0 and held:
  - sync2 goes low at edge 1.
  - UP→UP_CHK at edge 2.
  - `keys_level` and `press_pulse` go high after edge `DEBOUNCE_CYCLES`+1.
  - `press_pulse` lasts exactly one cycle.
- Release latency is symmetric, with `release_pulse` in place of `press_pulse`.
- Any raw pulse or gap lasting ≤ `DEBOUNCE_CYCLES`−1 sampled cycles is rejected.
- All outputs are registered; there is no combinational path from `key_n`.

## Configuration

- Macro: `KEY_AUTOREPEAT_EN`.
- Defined: each key adds a repeat counter that runs while the key is in DOWN or DN_CHK.
  - Counter ← 0 on entry to DOWN from UP_CHK.
  - Extra `press_pulse` at `REPEAT_DELAY` cycles after the accepted press, then every `REPEAT_PERIOD` cycles.
  - Repeat strobes stop when the FSM reaches UP.
  - `keys_level` is unaffected.
- Undefined: no repeat logic is synthesized. Exactly one `press_pulse` per accepted press. `REPEAT_*` parameters are ignored.

## Test plan

Scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3.

- Reset check: hold `reset_reset_n`=0 for 3 cycles with `key_n`=4'b0000 → all outputs 0 during reset. After release, `keys_level` becomes 4'b1111 with one `press_pulse`=4'b1111 five edges after the first post-reset sample.
- Clean press of key 0: `key_n[0]` low for 20 cycles, then high → `keys_level[0]` rises after edge 5 with a 1-cycle `press_pulse[0]`. `release_pulse[0]` fires 5 edges after the rising sample.
- Glitch rejection: `key_n[1]` low for 3 cycles, then high → `keys_level[1]` stays 0 and no strobes occur. Repeat with a 3-cycle high gap during a hold → `keys_level[1]` stays 1 and no `release_pulse`.
- Simultaneous keys: `key_n[2]` and `key_n[3]` fall on the same edge → both `press_pulse` bits fire in the same cycle and `any_press`=1 for exactly 1 cycle.
- Auto-repeat with `KEY_AUTOREPEAT_EN`: hold `key_n[0]` 30 cycles → strobes at the accept edge, +10, +13, +16, ... until release. Without the macro → a single strobe only.
- Reset mid-debounce: assert reset while key 3 is in UP_CHK with counter 2, then deassert with the key still held → no strobe until a full re-debounce, then `press_pulse[3]` fires once.

Source files
------------

// File: rtl/de1_key_conditioner.sv
// de1_key_conditioner: per-key synchronizer, debounce FSM and press/release strobes for DE1-SoC keys.
// Define KEY_AUTOREPEAT_EN to add held-key repeat strobes on press_pulse.
module de1_key_conditioner #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 32
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] keys_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic              any_press
);
  typedef enum logic [1:0] {UP, UP_CHK, DOWN, DN_CHK} state_t;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST   = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
`endif
  logic [N_KEYS-1:0] sync1_q, sync2_q, press_d;
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      any_press <= 1'b0;
    end else begin
      sync1_q   <= key_n;
      sync2_q   <= sync1_q;
      any_press <= |press_d;
    end
  end
  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic lvl_q, lvl_d, prs_q, prs_d, rel_q, rel_d, pressed_s;
    assign pressed_s        = ~sync2_q[k];
    assign keys_level[k]    = lvl_q;
    assign press_pulse[k]   = prs_q;
    assign release_pulse[k] = rel_q;
    assign press_d[k]       = prs_d;
`ifdef KEY_AUTOREPEAT_EN
    logic [CNT_W-1:0] rpt_q, rpt_d;
    logic rpt_hit;
    assign rpt_hit = rpt_q == RPT_LAST;
`endif
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lvl_d   = lvl_q;
      prs_d   = 1'b0;
      rel_d   = 1'b0;
      case (state_q)
        UP: begin
          state_d = pressed_s ? UP_CHK : UP;
          cnt_d   = pressed_s ? CNT_W'(1) : '0;
        end
        UP_CHK:
          if (!pressed_s) begin
            state_d = UP;
            cnt_d   = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d = DOWN;
            cnt_d   = '0;
            lvl_d   = 1'b1;
            prs_d   = 1'b1;
          end else cnt_d = cnt_q + CNT_W'(1);
        DOWN:
          if (!pressed_s) begin
            state_d = DN_CHK;
            cnt_d   = CNT_W'(1);
          end
        default:
          if (pressed_s) state_d = DOWN;
          else if (cnt_q == DEB_LAST) begin
            state_d = UP;
            cnt_d   = '0;
            lvl_d   = 1'b0;
            rel_d   = 1'b1;
          end else cnt_d = cnt_q + CNT_W'(1);
      endcase
`ifdef KEY_AUTOREPEAT_EN
      rpt_d = rpt_q;
      // The repeat timer keeps running through a DN_CHK bounce and dies only on the final release.
      if (state_q == UP_CHK && state_d == DOWN) rpt_d = '0;
      else if ((state_q == DOWN || state_q == DN_CHK) && state_d != UP) begin
        rpt_d = rpt_hit ? RPT_RELOAD : rpt_q + CNT_W'(1);
        prs_d = rpt_hit;
      end
`endif
    end
    always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
        state_q <= UP;
        cnt_q   <= '0;
        lvl_q   <= 1'b0;
        prs_q   <= 1'b0;
        rel_q   <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rpt_q   <= '0;
`endif
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        lvl_q   <= lvl_d;
        prs_q   <= prs_d;
        rel_q   <= rel_d;
`ifdef KEY_AUTOREPEAT_EN
        rpt_q   <= rpt_d;
`endif
      end
    end
  end
endmodule
